// File: rtl/liteic_req_router.sv
// liteic_req_router: routes master requests to decoded slave ports and returns responses in order
module liteic_req_router #(
   parameter int ADDR_WIDTH      = 16,
   parameter int DATA_WIDTH      = 32,
   parameter int NUM_REGIONS     = 1,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              m_req_valid_i,
   output logic                              m_req_ready_o,
   input  logic [ADDR_WIDTH-1:0]             m_req_addr_i,
   input  logic                              m_req_we_i,
   input  logic [DATA_WIDTH-1:0]             m_req_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]           m_req_be_i,
   output logic                              m_rsp_valid_o,
   input  logic                              m_rsp_ready_i,
   output logic [DATA_WIDTH-1:0]             m_rsp_rdata_o,
   output logic                              m_rsp_err_o,
   output logic [ADDR_WIDTH-1:0]             dec_addr_o,
   input  logic [NUM_REGIONS-1:0]            dec_rgn_select_i,
   input  logic                              dec_illegal_addr_i,
   output logic [NUM_REGIONS-1:0]            s_req_valid_o,
   input  logic [NUM_REGIONS-1:0]            s_req_ready_i,
   output logic [ADDR_WIDTH-1:0]             s_req_addr_o,
   output logic                              s_req_we_o,
   output logic [DATA_WIDTH-1:0]             s_req_wdata_o,
   output logic [DATA_WIDTH/8-1:0]           s_req_be_o,
   input  logic [NUM_REGIONS-1:0]            s_rsp_valid_i,
   output logic [NUM_REGIONS-1:0]            s_rsp_ready_o,
   input  logic [NUM_REGIONS*DATA_WIDTH-1:0] s_rsp_rdata_i,
   input  logic [NUM_REGIONS-1:0]            s_rsp_err_i
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int TW = $clog2(NUM_REGIONS + 1);
   localparam logic [TW-1:0] ERR = TW'(NUM_REGIONS);
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tgt_q, tgt_d, dec_tgt;
   logic [NUM_REGIONS-1:0] req_oh, rsp_oh;
   logic can_accept, req_acc, rsp_acc, busy, tgt_err;
   assign dec_addr_o    = m_req_addr_i;
   assign s_req_addr_o  = m_req_addr_i;
   assign s_req_we_o    = m_req_we_i;
   assign s_req_wdata_o = m_req_wdata_i;
   assign s_req_be_o    = m_req_be_i;
   // lowest selected region wins; illegal (or empty) select goes to the local error responder
   always_comb begin
      dec_tgt = ERR;
      if (!dec_illegal_addr_i)
         for (int k = NUM_REGIONS - 1; k >= 0; k--)
            if (dec_rgn_select_i[k]) dec_tgt = TW'(k);
   end
   // request routing, gated by free slots and by the single-target ordering rule
   always_comb begin
      req_oh = '0;
      rsp_oh = '0;
      for (int k = 0; k < NUM_REGIONS; k++) begin
         req_oh[k] = dec_tgt == TW'(k);
         rsp_oh[k] = tgt_q == TW'(k);
      end
      busy          = cnt_q != '0;
      tgt_err       = tgt_q == ERR;
      can_accept    = (cnt_q < CW'(MAX_OUTSTANDING)) && (!busy || tgt_q == dec_tgt);
      s_req_valid_o = req_oh & {NUM_REGIONS{m_req_valid_i & can_accept}};
      m_req_ready_o = can_accept & (dec_tgt == ERR ? 1'b1 : |(s_req_ready_i & req_oh));
      req_acc       = m_req_valid_i & m_req_ready_o;
   end
   // in-order response return: pass the owning slave through, or synthesize an error locally
   always_comb begin
      m_rsp_rdata_o = '0;
      for (int k = 0; k < NUM_REGIONS; k++)
         if (rsp_oh[k]) m_rsp_rdata_o = s_rsp_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      m_rsp_valid_o = busy & (tgt_err | |(s_rsp_valid_i & rsp_oh));
      m_rsp_err_o   = tgt_err | |(s_rsp_err_i & rsp_oh);
      s_rsp_ready_o = rsp_oh & {NUM_REGIONS{busy & m_rsp_ready_i}};
      rsp_acc       = m_rsp_valid_o & m_rsp_ready_i;
      cnt_d         = cnt_q + CW'(req_acc) - CW'(rsp_acc);
      tgt_d         = req_acc ? dec_tgt : tgt_q;
   end
   // outstanding count and the target they all share
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         tgt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         tgt_q <= tgt_d;
      end
   end
endmodule

// File: tb/tb_liteic_req_router.sv
// tb_liteic_req_router: randomized scoreboard bench with decoder and slave models
module tb_liteic_req_router;
   localparam int AW = 16, DW = 32, NR = 2, MO = 4, ERR = NR;
   typedef struct packed { int k; logic [DW-1:0] d; logic e; } sent_t;

   logic clk_i = 1'b0;
   logic rst_i;
   logic m_req_valid_i, m_req_ready_o, m_req_we_i;
   logic [AW-1:0] m_req_addr_i;
   logic [DW-1:0] m_req_wdata_i;
   logic [DW/8-1:0] m_req_be_i;
   logic m_rsp_valid_o, m_rsp_ready_i, m_rsp_err_o;
   logic [DW-1:0] m_rsp_rdata_o;
   logic [AW-1:0] dec_addr_o;
   logic [NR-1:0] dec_rgn_select_i;
   logic dec_illegal_addr_i;
   logic [NR-1:0] s_req_valid_o, s_req_ready_i, s_rsp_valid_i, s_rsp_ready_o, s_rsp_err_i;
   logic [AW-1:0] s_req_addr_o;
   logic s_req_we_o;
   logic [DW-1:0] s_req_wdata_o;
   logic [DW/8-1:0] s_req_be_o;
   logic [NR*DW-1:0] s_rsp_rdata_i;

   int checks = 0, errors = 0;
   int outq[$];
   sent_t sq[$];
   logic [DW:0] expq[$];
   bit acc_last = 0;

   always #5 clk_i = ~clk_i;

   liteic_req_router #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGIONS(NR), .MAX_OUTSTANDING(MO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m_req_valid_i(m_req_valid_i), .m_req_ready_o(m_req_ready_o), .m_req_addr_i(m_req_addr_i),
      .m_req_we_i(m_req_we_i), .m_req_wdata_i(m_req_wdata_i), .m_req_be_i(m_req_be_i),
      .m_rsp_valid_o(m_rsp_valid_o), .m_rsp_ready_i(m_rsp_ready_i), .m_rsp_rdata_o(m_rsp_rdata_o),
      .m_rsp_err_o(m_rsp_err_o), .dec_addr_o(dec_addr_o), .dec_rgn_select_i(dec_rgn_select_i),
      .dec_illegal_addr_i(dec_illegal_addr_i), .s_req_valid_o(s_req_valid_o), .s_req_ready_i(s_req_ready_i),
      .s_req_addr_o(s_req_addr_o), .s_req_we_o(s_req_we_o), .s_req_wdata_o(s_req_wdata_o),
      .s_req_be_o(s_req_be_o), .s_rsp_valid_i(s_rsp_valid_i), .s_rsp_ready_o(s_rsp_ready_o),
      .s_rsp_rdata_i(s_rsp_rdata_i), .s_rsp_err_i(s_rsp_err_i));

   // address map: top bits 0 -> region 0, 1 -> region 1, 2 -> regions 0 and 1 overlap, 3 -> unmapped
   always_comb begin
      dec_rgn_select_i   = '0;
      dec_illegal_addr_i = 1'b0;
      case (dec_addr_o[AW-1:AW-2])
         2'd0: dec_rgn_select_i = 2'b01;
         2'd1: dec_rgn_select_i = 2'b10;
         2'd2: dec_rgn_select_i = 2'b11;
         default: dec_illegal_addr_i = 1'b1;
      endcase
   end

   function automatic int tgt_of(logic [AW-1:0] a);
      return a[AW-1:AW-2] == 2'd3 ? ERR : a[AW-1:AW-2] == 2'd1 ? 1 : 0;
   endfunction

   task automatic chk(string n, logic [63:0] a, logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %h expected %h", n, a, e);
      end
   endtask

   int t, h;
   bit can, exp_rdy, exp_rv;
   logic [NR-1:0] exp_sv, exp_sr;
   sent_t s;
   // reference model of routing/acceptance; records accepted requests into the scoreboard
   always @(negedge clk_i) begin
      if (rst_i) begin
         outq.delete();
         sq.delete();
         acc_last = 0;
      end else begin
         t = tgt_of(m_req_addr_i);
         can = outq.size() < MO && (outq.size() == 0 || outq[0] == t);
         exp_rdy = can && (t == ERR || s_req_ready_i[t]);
         exp_sv = '0;
         if (m_req_valid_i && can && t != ERR) exp_sv[t] = 1'b1;
         h = outq.size() == 0 ? -1 : outq[0];
         exp_rv = h < 0 ? 1'b0 : h == ERR ? 1'b1 : s_rsp_valid_i[h];
         exp_sr = '0;
         if (h >= 0 && h != ERR && m_rsp_ready_i) exp_sr[h] = 1'b1;
         chk("s_req_valid", 64'(s_req_valid_o), 64'(exp_sv));
         chk("m_rsp_valid", 64'(m_rsp_valid_o), 64'(exp_rv));
         chk("s_rsp_ready", 64'(s_rsp_ready_o), 64'(exp_sr));
         if (m_req_valid_i) begin
            chk("m_req_ready", 64'(m_req_ready_o), 64'(exp_rdy));
            chk("addr_pass", 64'({dec_addr_o, s_req_addr_o}), 64'({2{m_req_addr_i}}));
            chk("payload_pass", 64'({s_req_we_o, s_req_wdata_o, s_req_be_o}),
                64'({m_req_we_i, m_req_wdata_i, m_req_be_i}));
         end
         if ((s_rsp_valid_i & s_rsp_ready_o) != '0 && sq.size() > 0) void'(sq.pop_front());
         if (m_rsp_valid_o && m_rsp_ready_i && outq.size() > 0) void'(outq.pop_front());
         acc_last = m_req_valid_i && m_req_ready_o;
         if (acc_last) begin
            outq.push_back(t);
            if (t == ERR) expq.push_back({1'b1, 32'h0});
            else begin
               s.k = t;
               s.d = $urandom;
               s.e = 1'($urandom_range(1));
               sq.push_back(s);
               expq.push_back({s.e, s.d});
            end
         end
      end
   end

   logic [DW:0] x;
   // response monitor: every master response handshake must match the oldest expectation
   always @(negedge clk_i) begin
      if (rst_i) expq.delete();
      else if (m_rsp_valid_o && m_rsp_ready_i) begin
         if (expq.size() == 0) chk("rsp_unexpected", 64'(m_rsp_valid_o), 64'(0));
         else begin
            x = expq.pop_front();
            chk("rsp_rdata", 64'(m_rsp_rdata_o), 64'(x[DW-1:0]));
            chk("rsp_err", 64'(m_rsp_err_o), 64'(x[DW]));
         end
      end
   end

   task automatic step(int pv, int pr, int pm, int ps, int mode, bit stray);
      @(posedge clk_i);
      #1;
      if (!m_req_valid_i || acc_last) begin
         m_req_valid_i = $urandom_range(99) < pv;
         m_req_addr_i  = AW'($urandom);
         if (mode >= 0) m_req_addr_i[AW-1:AW-2] = 2'(mode);
         m_req_we_i    = 1'($urandom_range(1));
         m_req_wdata_i = $urandom;
         m_req_be_i    = 4'($urandom);
      end
      for (int k = 0; k < NR; k++) s_req_ready_i[k] = $urandom_range(99) < pr;
      m_rsp_ready_i = $urandom_range(99) < pm;
      s_rsp_valid_i = '0;
      s_rsp_rdata_i = {$urandom, $urandom};
      s_rsp_err_i   = 2'($urandom);
      if (sq.size() > 0 && $urandom_range(99) < ps) begin
         s_rsp_valid_i[sq[0].k] = 1'b1;
         s_rsp_rdata_i[sq[0].k*DW +: DW] = sq[0].d;
         s_rsp_err_i[sq[0].k] = sq[0].e;
      end
      if (stray) begin
         s_rsp_valid_i[1] = 1'b1;
         m_rsp_ready_i = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      m_req_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   int ph[6][6] = '{
      '{70, 70, 70, 70, -1, 400},
      '{100, 100, 0, 100, 0, 20},
      '{100, 100, 100, 60, 0, 20},
      '{80, 60, 70, 60, 3, 60},
      '{100, 100, 100, 100, -1, 300},
      '{90, 40, 50, 40, -1, 400}
   };

   initial begin
      rst_i = 1'b1;
      m_req_valid_i = 1'b0;
      m_req_addr_i = '0;
      m_req_we_i = 1'b0;
      m_req_wdata_i = '0;
      m_req_be_i = '0;
      m_rsp_ready_i = 1'b0;
      s_req_ready_i = '0;
      s_rsp_valid_i = '0;
      s_rsp_rdata_i = '0;
      s_rsp_err_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      for (int p = 0; p < 6; p++)
         for (int i = 0; i < ph[p][5]; i++) step(ph[p][0], ph[p][1], ph[p][2], ph[p][3], ph[p][4], 1'b0);
      for (int i = 0; i < 4; i++) step(100, 100, 0, 0, 1, 1'b0);
      do_reset();
      for (int i = 0; i < 6; i++) step(0, 100, 100, 0, -1, 1'b1);
      for (int i = 0; i < 300; i++) step(70, 70, 70, 70, -1, 1'b0);
      for (int i = 0; i < 200 && outq.size() > 0; i++) step(0, 100, 100, 100, -1, 1'b0);
      @(negedge clk_i);
      chk("drain", 64'(outq.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
